// File: rtl/entry_pkg.sv
// Shared types and constants for the keypad operand entry stage.
package entry_pkg;

  typedef enum logic [1:0] {S_OP1, S_OP2, S_FIRE, S_HOLD} entry_state_t;

  localparam int         MAX_DIGITS = 3;
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_BACK   = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;
  localparam logic [9:0] MAX_POS    = 10'd127;
  localparam logic [9:0] MAX_NEG    = 10'd128;

  function automatic logic in_range(input logic [9:0] mag, input logic neg);
    return neg ? (mag <= MAX_NEG) : (mag <= MAX_POS);
  endfunction

  // 128 negates to 8'h80 because only the low byte takes part.
  function automatic logic [7:0] to_operand(input logic [9:0] mag, input logic neg);
    return neg ? (~mag[7:0] + 8'd1) : mag[7:0];
  endfunction

endpackage

// File: rtl/operand_entry_fsm_bcd3_to_bin.sv
// Three BCD digits to a 10-bit binary magnitude, using shift-add constant multiplies.
module bcd3_to_bin (
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [9:0] mag
);

  logic [9:0] w2, w1, w0;

  assign w2  = {6'd0, d2};
  assign w1  = {6'd0, d1};
  assign w0  = {6'd0, d0};
  assign mag = (w2 << 6) + (w2 << 5) + (w2 << 2) + (w1 << 3) + (w1 << 1) + w0;

endmodule

// File: rtl/operand_entry_fsm.sv
// Keypad operand entry: builds two signed 8-bit operands and hands them to the multiplier.
module operand_entry_fsm
  import entry_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       signo,
  input  logic       mult_ready,
  output logic [7:0] numero1_o,
  output logic [7:0] numero2_o,
  output logic       valid,
  output logic       error,
  output logic [9:0] entry_value,
  output logic       entry_sel
);

  entry_state_t state, state_n;
  logic [3:0]   d2, d1, d0, d2_n, d1_n, d0_n;
  logic [1:0]   count, count_n;
  logic [7:0]   num1_n, num2_n;
  logic         error_n;

  bcd3_to_bin u_bcd (
    .d2  (d2),
    .d1  (d1),
    .d0  (d0),
    .mag (entry_value)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_n = state;
    d2_n    = d2;
    d1_n    = d1;
    d0_n    = d0;
    count_n = count;
    num1_n  = numero1_o;
    num2_n  = numero2_o;
    error_n = 1'b0;

    case (state)
      S_OP1, S_OP2: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (count < 2'(MAX_DIGITS)) begin
              d2_n    = d1;
              d1_n    = d0;
              d0_n    = key_code;
              count_n = count + 2'd1;
            end
          end else if (key_code == KEY_BACK) begin
            if (count != 2'd0) begin
              d0_n    = d1;
              d1_n    = d2;
              d2_n    = 4'd0;
              count_n = count - 2'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            {d2_n, d1_n, d0_n} = '0;
            count_n            = 2'd0;
            if (state == S_OP2) begin
              num1_n  = 8'd0;
              state_n = S_OP1;
            end
          end else if (key_code == KEY_ENTER) begin
            // Digits are dropped whether or not the value is accepted.
            {d2_n, d1_n, d0_n} = '0;
            count_n            = 2'd0;
            if (in_range(entry_value, signo)) begin
              if (state == S_OP1) begin
                num1_n  = to_operand(entry_value, signo);
                state_n = S_OP2;
              end else begin
                num2_n  = to_operand(entry_value, signo);
                state_n = S_FIRE;
              end
            end else begin
              error_n = 1'b1;
            end
          end
        end
      end
      S_FIRE:  state_n = S_HOLD;
      S_HOLD:  if (mult_ready) state_n = S_OP1;
      default: state_n = S_OP1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_OP1;
      d2        <= 4'd0;
      d1        <= 4'd0;
      d0        <= 4'd0;
      count     <= 2'd0;
      numero1_o <= 8'd0;
      numero2_o <= 8'd0;
      valid     <= 1'b0;
      error     <= 1'b0;
      entry_sel <= 1'b0;
    end else begin
      state     <= state_n;
      d2        <= d2_n;
      d1        <= d1_n;
      d0        <= d0_n;
      count     <= count_n;
      numero1_o <= num1_n;
      numero2_o <= num2_n;
      valid     <= (state == S_FIRE);
      error     <= error_n;
      entry_sel <= (state_n == S_OP2);
    end
  end

endmodule
